// File: rtl/uart_mem_dump.sv
// rtl/uart_mem_dump.sv - rib read master that dumps memory words out a UART TX pin
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start_i           single-cycle start request (only honoured in IDLE)
//   base_addr_i       first word address, low two bits ignored
//   word_cnt_i        number of 32-bit words to dump (0 completes immediately)
//   req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i
//                     rib master port; read-only, rdata valid in the req cycle
//   tx_pin            registered UART output, idle high, 8N1, BAUD_DIV cycles/bit
//   busy_o            high while reading/sending
//   done_o            one-cycle pulse when a dump completes
module uart_mem_dump #(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  output logic             req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             tx_pin,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t           state, state_nxt;
  logic [31:0]      addr;
  logic [31:0]      shreg;
  logic [CNT_W-1:0] remain;
  logic [BW-1:0]    baud_cnt;
  logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [1:0]       byte_idx;
  logic             bit_end;
  logic             word_end;

  assign bit_end  = (state == SEND) && (baud_cnt == BAUD_LAST);
  assign word_end = bit_end && (bit_idx == 4'd9) && (byte_idx == 2'd3);

  assign mem_we_o    = 1'b0;
  assign mem_wdata_o = 32'h0;
  // addr only changes on entry to READ, so it doubles as the held bus address
  assign mem_addr_o  = addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_o     = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = (word_cnt_i != '0) ? READ : FIN;
      READ: begin
        req_o     = 1'b1;
        busy_o    = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        busy_o = 1'b1;
        if (word_end) state_nxt = (remain == CNT_W'(1)) ? FIN : READ;
      end
      FIN: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= 32'h0;
      shreg    <= 32'h0;
      remain   <= '0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      byte_idx <= 2'd0;
      tx_pin   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_pin <= 1'b1;
          if (start_i && (word_cnt_i != '0)) begin
            addr   <= base_addr_i & 32'hFFFF_FFFC;
            remain <= word_cnt_i;
          end
        end
        READ: begin
          shreg    <= mem_rdata_i;
          baud_cnt <= '0;
          bit_idx  <= 4'd0;
          byte_idx <= 2'd0;
          tx_pin   <= 1'b0;  // start bit of byte 0 appears with the first SEND cycle
        end
        SEND: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= 4'd0;
              if (byte_idx == 2'd3) begin
                tx_pin <= 1'b1;
                remain <= remain - 1'b1;
                // advance only when another READ follows so the bus address holds
                if (remain != CNT_W'(1)) addr <= addr + 32'd4;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                shreg    <= {8'h00, shreg[31:8]};
                tx_pin   <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_pin  <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
            end
          end
        end
        default: tx_pin <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_dump.sv
// tb/tb_uart_mem_dump.sv - self-checking bench for uart_mem_dump
module tb_uart_mem_dump;

  localparam int B    = 4;
  localparam int WC   = 1 + 40 * B;  // cycles per word
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_cnt;
  logic        req, mem_we, tx_pin, busy, done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] salt = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  uart_mem_dump #(.BAUD_DIV(B), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base_addr),
    .word_cnt_i(word_cnt), .req_o(req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .tx_pin(tx_pin),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a, input logic [31:0] s);
    if (a == 32'h1000_0000) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign mem_rdata = word_at(mem_addr, salt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic cap_tx [0:MAXC-1];

  task automatic run_dump(input logic [31:0] b, input logic [15:0] cnt, input bit inject,
                          input int exp_done, input logic [31:0] exp_first, input string tag);
    int n, last_send, limit, done_cnt, done_at, tx_err, req_err, busy_err, frame_err;
    logic [31:0] abase, wd, got;
    logic [31:0] addrs[$];
    logic exp_tx, exp_req, exp_busy;
    n = int'(cnt);
    last_send = WC * n;
    limit = exp_done + 20;
    done_cnt = 0; done_at = -1; tx_err = 0; req_err = 0; busy_err = 0; frame_err = 0;
    abase = b & 32'hFFFF_FFFC;
    salt = $urandom;
    @(negedge clk);
    start = 1'b1; base_addr = b; word_cnt = cnt;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject && c == 50) begin
        start = 1'b1; base_addr = 32'h2000_0000; word_cnt = 16'd5;
      end
      cap_tx[c] = tx_pin;
      if (req) addrs.push_back(mem_addr);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c <= last_send) begin
        int p, r, q, bi, k;
        p = c - 1; r = p % WC;
        exp_req = (r == 0); exp_busy = 1'b1;
        if (r == 0) exp_tx = 1'b1;
        else begin
          q = r - 1; bi = q / (10 * B); k = (q % (10 * B)) / B;
          wd = word_at(abase + 32'(4 * (p / WC)), salt);
          exp_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : wd[bi * 8 + k - 1];
        end
      end else begin
        exp_req = 1'b0; exp_busy = 1'b0; exp_tx = 1'b1;
      end
      if (tx_pin !== exp_tx) tx_err++;
      if (req !== exp_req) req_err++;
      if (busy !== exp_busy) busy_err++;
    end
    start = 1'b0;
    check({tag, " tx_wave_errs"}, 32'(tx_err), 32'd0);
    check({tag, " req_errs"}, 32'(req_err), 32'd0);
    check({tag, " busy_errs"}, 32'(busy_err), 32'd0);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " done_cycle"}, 32'(done_at), 32'(exp_done));
    check({tag, " read_count"}, 32'(addrs.size()), 32'(n));
    if (n > 0 && addrs.size() > 0) check({tag, " first_addr"}, addrs[0], exp_first);
    for (int i = 0; i < n && i < addrs.size(); i++)
      check($sformatf("%s addr%0d", tag, i), addrs[i], abase + 32'(4 * i));
    for (int w = 0; w < n; w++) begin
      got = 32'h0;
      for (int by = 0; by < 4; by++) begin
        for (int k = 0; k < 10; k++) begin
          int idx;
          logic bv;
          idx = 1 + w * WC + 1 + by * 10 * B + k * B + B / 2;
          bv = cap_tx[idx];
          if (k == 0 && bv !== 1'b0) frame_err++;
          if (k == 9 && bv !== 1'b1) frame_err++;
          if (k >= 1 && k <= 8) got[by * 8 + k - 1] = bv;
        end
      end
      check($sformatf("%s word%0d", tag, w), got, word_at(abase + 32'(4 * w), salt));
    end
    check({tag, " frame_errs"}, 32'(frame_err), 32'd0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    bit          inject;
    logic [31:0] exp_first;
    int          exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int rc, rd, rtx;
    vecs[0] = '{32'h1000_0000, 16'd1, 1'b0, 32'h1000_0000, 1 + 1 * WC};
    vecs[1] = '{32'h1000_0002, 16'd3, 1'b0, 32'h1000_0000, 1 + 3 * WC};
    vecs[2] = '{32'h1234_5670, 16'd0, 1'b0, 32'h0000_0000, 1};
    vecs[3] = '{32'h1000_0000, 16'd2, 1'b1, 32'h1000_0000, 1 + 2 * WC};
    vecs[4] = '{32'hFFFF_FFFC, 16'd2, 1'b0, 32'hFFFF_FFFC, 1 + 2 * WC};

    rst = 1'b1; start = 1'b0; base_addr = 32'h0; word_cnt = 16'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d tx", i), {31'h0, tx_pin}, 32'd1);
      check($sformatf("reset%0d req", i), {31'h0, req}, 32'd0);
      check($sformatf("reset%0d busy", i), {31'h0, busy}, 32'd0);
      check($sformatf("reset%0d done", i), {31'h0, done}, 32'd0);
      start = ~start;
    end
    check("reset addr", mem_addr, 32'h0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("post_reset tx", {31'h0, tx_pin}, 32'd1);
    check("post_reset req", {31'h0, req}, 32'd0);
    check("post_reset busy", {31'h0, busy}, 32'd0);
    check("post_reset done", {31'h0, done}, 32'd0);

    for (int v = 0; v < 5; v++)
      run_dump(vecs[v].base, vecs[v].cnt, vecs[v].inject, vecs[v].exp_done,
               vecs[v].exp_first, $sformatf("vec%0d", v));

    for (int r = 0; r < 4; r++) begin
      logic [31:0] rb;
      logic [15:0] rcnt;
      rb = $urandom;
      rcnt = 16'($urandom_range(1, 3));
      run_dump(rb, rcnt, 1'b0, 1 + int'(rcnt) * WC, rb & 32'hFFFF_FFFC, $sformatf("rand%0d", r));
    end

    // reset during the second byte of the first word
    @(negedge clk);
    start = 1'b1; base_addr = 32'h1000_0000; word_cnt = 16'd2;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midreset tx", {31'h0, tx_pin}, 32'd1);
    check("midreset req", {31'h0, req}, 32'd0);
    check("midreset busy", {31'h0, busy}, 32'd0);
    check("midreset done", {31'h0, done}, 32'd0);
    rst = 1'b0;
    rc = 0; rd = 0; rtx = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (req) rc++;
      if (done) rd++;
      if (tx_pin !== 1'b1) rtx++;
    end
    check("after_reset reqs", 32'(rc), 32'd0);
    check("after_reset dones", 32'(rd), 32'd0);
    check("after_reset tx_low", 32'(rtx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
